regfile_march_bist: RTL and testbench
=====================================

# regfile_march_bist

Built-in self-test engine that drives the write port W0 and read port R0 of a 128x65 register-file macro. It runs a March C- sequence and reports pass/fail with the first failing address and march element. It sits beside the regfile macro and owns the W0/R0 port bundles while `busy` is high. The surrounding logic muxes those ports back to functional traffic when the engine is idle.

## Interface
- `ADDR_W`, 7, address width
- `DEPTH`, 128, number of entries tested (addresses 0..DEPTH-1; DEPTH ≤ 2^ADDR_W; power of two not required)
- `DATA_W`, 65, word width
- `clock` input 1: the block's single clock. Drives all state; it is passed through to the macro port clocks.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: launch request; sampled only in IDLE or DONE
- `busy` output 1: march in progress
- `done` output 1: sticky completion flag, cleared by the next accepted start
- `fail` output 1: sticky mismatch flag, valid when done=1
- `fail_addr` output ADDR_W: address of the first mismatching read
- `fail_elem` output 3: march element (1..5) of the first mismatch
- `W0_addr` output ADDR_W; `W0_en` output 1; `W0_clk` output 1 (= clock); `W0_data` output DATA_W
- `R0_addr` output ADDR_W; `R0_en` output 1; `R0_clk` output 1 (= clock)
- `R0_data` input DATA_W: combinational read data from the macro, valid in the same cycle R0_addr/R0_en are driven

## Operation
- Backgrounds: B0 = all zeros, B1 = all ones (DATA_W bits).
- Elements, where ⇑ is address 0→DEPTH-1 and ⇓ is DEPTH-1→0:
  - M0 ⇑ w(B0)
  - M1 ⇑ r(B0), w(B1)
  - M2 ⇑ r(B1), w(B0)
  - M3 ⇓ r(B0), w(B1)
  - M4 ⇓ r(B1), w(B0)
  - M5 ⇑ r(B0)
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE → RUN on start=1. This clears done, fail, fail_addr and fail_elem, and loads element 0 at address 0.
  - RUN → DONE after the last op of M5, or on the first mismatch.
  - Every other condition holds the current state.
- Sub-phase within RUN for M1–M4: a READ cycle, then a WRITE cycle at the same address, then the address steps. M0 and M5 have one op per address.
- READ cycle: R0_en=1 and R0_addr=current address. At the clock edge, R0_data is compared against the expected background. Any differing bit is a mismatch (X/Z on R0_data is a mismatch at the bench level).
- On a mismatch: fail=1, fail_addr=current address, fail_elem=element number, then go to DONE. No further W0/R0 activity occurs.
- WRITE cycle: W0_en=1, W0_addr=current address, W0_data=target background.
- Address counter wraps between elements: an ⇑ element ends at DEPTH-1, and ⇓ elements start at DEPTH-1 and end at 0.
- Outside READ cycles R0_en=0; outside WRITE cycles W0_en=0. Address and data outputs hold their last value.
- busy=1 exactly while in RUN. `start` is ignored during RUN.

## Timing
- Reset values: busy=0, done=0, fail=0, fail_addr=0, fail_elem=0, W0_en=0, W0_addr=0, W0_data=0, R0_en=0, R0_addr=0. The state is IDLE.
- Reset asserted mid-run forces all of the above immediately (asynchronously). After reset, memory contents are unspecified and no port activity occurs until the next start.
- Start sampled at edge t: busy=1 from t+1, and the first M0 write (addr 0, data B0) is driven in cycle t+1.
- Passing run length is 10·DEPTH cycles (1280 at the defaults): M0 and M5 take DEPTH cycles each, and M1–M4 take 2·DEPTH each. In the cycle after the final M5 read, busy=0 and done=1.
- Failing run: done=1 and busy=0 in the cycle after the mismatching READ edge.
- All outputs are registered; the only combinational path is R0_data into the compare.

## Test plan
- Fault-free 128x65 model, start pulse:
  - busy is high for exactly 1280 cycles, then done=1, fail=0.
  - Exactly 640 W0_en cycles and 640 R0_en cycles are seen.
- Sequence check:
  - Cycle t+1: W0 addr 0, data 0.
  - First M1 cycle: R0 addr 0, then W0 addr 0, data all ones.
  - First M3 READ: R0_addr=127.
- Stuck-at-0 on bit 64 of address 5 → fail=1, fail_elem=2, fail_addr=5; the run stops with no further writes.
- Stuck-at-1 on bit 0 of address 127 → fail=1, fail_elem=1, fail_addr=127.
- Start pulse during RUN at cycle 200 is ignored and the run completes normally. A start pulse in DONE clears done/fail and reruns.
- Reset asserted at cycle 300 of a run:
  - busy, W0_en and R0_en drop immediately, and all outputs take their reset values.
  - A subsequent start completes a full 1280-cycle pass.

Source files
------------

// File: rtl/regfile_march_bist.sv
// March C- self-test engine for a DEPTH x DATA_W register file driven through its W0/R0 ports.
// Reports the first failing address and march element; all outputs are registered.
module regfile_march_bist #(
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128,
    parameter int DATA_W = 65
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [ADDR_W-1:0] W0_addr,
    output logic              W0_en,
    output logic              W0_clk,
    output logic [DATA_W-1:0] W0_data,
    output logic [ADDR_W-1:0] R0_addr,
    output logic              R0_en,
    output logic              R0_clk,
    input  logic [DATA_W-1:0] R0_data
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] ONES      = {DATA_W{1'b1}};

    state_t            state;
    logic [2:0]        elem;
    logic [ADDR_W-1:0] addr;

    logic              descending;
    logic              at_end;
    logic              mismatch;
    logic              last_op;
    logic              nxt_read;
    logic [2:0]        nxt_elem;
    logic [ADDR_W-1:0] nxt_addr;

    assign W0_clk = clock;
    assign R0_clk = clock;

    // Next-op sequencer: elem/addr always describe the op currently on the ports.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        descending = (elem == 3'd3) || (elem == 3'd4);
        at_end     = descending ? (addr == '0) : (addr == LAST_ADDR);
        mismatch   = R0_en && (R0_data != (((elem == 3'd2) || (elem == 3'd4)) ? ONES : '0));
        nxt_elem   = elem;
        nxt_addr   = addr;
        nxt_read   = 1'b0;
        last_op    = 1'b0;
        if (R0_en && (elem != 3'd5)) begin
            nxt_read = 1'b0;                          // write follows read at the same address
        end else if (at_end) begin
            if (elem == 3'd5) begin
                last_op = 1'b1;
            end else begin
                nxt_elem = elem + 3'd1;
                nxt_addr = ((nxt_elem == 3'd3) || (nxt_elem == 3'd4)) ? LAST_ADDR : '0;
                nxt_read = 1'b1;
            end
        end else begin
            nxt_addr = descending ? (addr - 1'b1) : (addr + 1'b1);
            nxt_read = (elem != 3'd0);
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            elem      <= '0;
            addr      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            W0_en     <= 1'b0;
            W0_addr   <= '0;
            W0_data   <= '0;
            R0_en     <= 1'b0;
            R0_addr   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        fail      <= 1'b0;
                        fail_addr <= '0;
                        fail_elem <= '0;
                        elem      <= '0;
                        addr      <= '0;
                        W0_en     <= 1'b1;
                        W0_addr   <= '0;
                        W0_data   <= '0;
                        R0_en     <= 1'b0;
                    end
                end
                RUN: begin
                    if (mismatch || last_op) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        W0_en <= 1'b0;
                        R0_en <= 1'b0;
                        if (mismatch) begin
                            fail      <= 1'b1;
                            fail_addr <= addr;
                            fail_elem <= elem;
                        end
                    end else begin
                        elem  <= nxt_elem;
                        addr  <= nxt_addr;
                        R0_en <= nxt_read;
                        W0_en <= !nxt_read;
                        if (nxt_read) begin
                            R0_addr <= nxt_addr;
                        end else begin
                            W0_addr <= nxt_addr;
                            W0_data <= ((nxt_elem == 3'd1) || (nxt_elem == 3'd3)) ? ONES : '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_march_bist.sv
// Self-checking bench: behavioural regfile with injectable stuck-at cells and a loop-level
// March C- reference model that predicts pass/fail, failing element/address and op counts.
module tb_regfile_march_bist;

    localparam int ADDR_W  = 7;
    localparam int DEPTH   = 128;
    localparam int DATA_W  = 65;
    localparam int TRACE_N = 1400;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              busy, done, fail;
    logic [ADDR_W-1:0] fail_addr;
    logic [2:0]        fail_elem;
    logic [ADDR_W-1:0] W0_addr, R0_addr;
    logic              W0_en, W0_clk, R0_en, R0_clk;
    logic [DATA_W-1:0] W0_data, R0_data;

    regfile_march_bist #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset), .start(start),
        .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr), .fail_elem(fail_elem),
        .W0_addr(W0_addr), .W0_en(W0_en), .W0_clk(W0_clk), .W0_data(W0_data),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_clk(R0_clk), .R0_data(R0_data)
    );

    always #5 clock = ~clock;

    localparam logic [DATA_W-1:0] ONES = {DATA_W{1'b1}};

    // Register-file model with per-cell stuck-at masks applied on read.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] sa0 [DEPTH];
    logic [DATA_W-1:0] sa1 [DEPTH];

    always @(posedge W0_clk) if (W0_en) mem[W0_addr] <= W0_data;
    assign R0_data = (mem[R0_addr] & ~sa0[R0_addr]) | sa1[R0_addr];

    // Port activity monitor, sampled on the falling edge.
    int cyc = 0, wr_cnt = 0, rd_cnt = 0, last_len = 0, last_wr = 0, last_rd = 0, idle_act = 0;
    logic              tr_w0en   [TRACE_N];
    logic [ADDR_W-1:0] tr_w0addr [TRACE_N];
    logic [DATA_W-1:0] tr_w0data [TRACE_N];
    logic              tr_r0en   [TRACE_N];
    logic [ADDR_W-1:0] tr_r0addr [TRACE_N];

    always @(negedge clock) begin
        if (busy) begin
            if (cyc < TRACE_N) begin
                tr_w0en[cyc]   = W0_en;
                tr_w0addr[cyc] = W0_addr;
                tr_w0data[cyc] = W0_data;
                tr_r0en[cyc]   = R0_en;
                tr_r0addr[cyc] = R0_addr;
            end
            cyc    = cyc + 1;
            wr_cnt = wr_cnt + int'(W0_en);
            rd_cnt = rd_cnt + int'(R0_en);
        end else begin
            if (cyc != 0) begin
                last_len = cyc;
                last_wr  = wr_cnt;
                last_rd  = rd_cnt;
            end
            cyc    = 0;
            wr_cnt = 0;
            rd_cnt = 0;
            if (W0_en || R0_en) idle_act = idle_act + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic clear_faults();
        for (int a = 0; a < DEPTH; a++) begin
            sa0[a] = '0;
            sa1[a] = '0;
        end
    endtask

    task automatic set_fault(input int a, input int b, input bit stuck_one);
        clear_faults();
        if (stuck_one) sa1[a][b] = 1'b1;
        else           sa0[a][b] = 1'b1;
    endtask

    // Reference: walk the six March C- elements over an ideal array seen through the fault masks.
    function automatic void march_model(output bit f, output int fe, output int fa,
                                        output int cycles, output int wr, output int rd);
        logic [DATA_W-1:0] m [DEPTH];
        logic [DATA_W-1:0] obs;
        logic [DATA_W-1:0] expv;
        int a;
        f = 1'b0; fe = 0; fa = 0; cycles = 0; wr = 0; rd = 0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < DEPTH; k++) begin
                a = (e == 3 || e == 4) ? DEPTH - 1 - k : k;
                if (e != 0) begin
                    rd++;
                    cycles++;
                    obs  = (m[a] & ~sa0[a]) | sa1[a];
                    expv = (e == 2 || e == 4) ? ONES : '0;
                    if (obs != expv) begin
                        f = 1'b1; fe = e; fa = a;
                        return;
                    end
                end
                if (e != 5) begin
                    wr++;
                    cycles++;
                    m[a] = (e == 1 || e == 3) ? ONES : '0;
                end
            end
        end
    endfunction

    // One march from IDLE/DONE; poke_at>0 pulses start again at that busy cycle.
    task automatic run_march(input string tag, input int poke_at);
        bit f;
        int fe, fa, n_cyc, n_wr, n_rd;
        march_model(f, fe, fa, n_cyc, n_wr, n_rd);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, ".busy_after_start"}, busy, 1'b1);
        check({tag, ".done_cleared"}, done, 1'b0);
        check({tag, ".fail_cleared"}, fail, 1'b0);
        for (int i = 0; i < 3000 && !done; i++) begin
            tick();
            if (poke_at > 0 && cyc == poke_at && busy) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        check({tag, ".done"}, done, 1'b1);
        check({tag, ".busy_low"}, busy, 1'b0);
        check({tag, ".fail"}, fail, f);
        if (f) begin
            check({tag, ".fail_addr"}, fail_addr, 128'(fa));
            check({tag, ".fail_elem"}, fail_elem, 128'(fe));
        end
        check({tag, ".busy_cycles"}, 128'(last_len), 128'(n_cyc));
        check({tag, ".w0_ops"}, 128'(last_wr), 128'(n_wr));
        check({tag, ".r0_ops"}, 128'(last_rd), 128'(n_rd));
    endtask

    initial begin
        int ra, rb;
        bit rp;
        clear_faults();
        tick();
        tick();
        check("reset.busy", busy, 1'b0);
        check("reset.done", done, 1'b0);
        check("reset.ports", {W0_en, R0_en, W0_addr, R0_addr, W0_data}, '0);
        reset = 1'b0;
        tick();

        run_march("pass", 0);
        check("pass.len_1280", 128'(last_len), 128'(10 * DEPTH));
        check("pass.w0_640", 128'(last_wr), 128'(5 * DEPTH));
        check("pass.r0_640", 128'(last_rd), 128'(5 * DEPTH));
        check("seq.first_w0", {tr_w0en[0], tr_r0en[0], tr_w0addr[0], tr_w0data[0]}, {2'b10, 72'd0});
        check("seq.m1_read", {tr_r0en[DEPTH], tr_w0en[DEPTH], tr_r0addr[DEPTH]}, {2'b10, 7'd0});
        check("seq.m1_write", {tr_w0en[DEPTH+1], tr_w0addr[DEPTH+1], tr_w0data[DEPTH+1]},
              {1'b1, 7'd0, ONES});
        check("seq.m3_first_read", {tr_r0en[5*DEPTH], tr_r0addr[5*DEPTH]}, {1'b1, 7'd127});

        set_fault(5, 64, 1'b0);
        run_march("sa0_a5_b64", 0);
        check("sa0.fail_elem_2", fail_elem, 3'd2);
        check("sa0.fail_addr_5", fail_addr, 7'd5);
        repeat (5) tick();
        check("sa0.quiet_after", {W0_en, R0_en, busy}, 3'b000);

        set_fault(127, 0, 1'b1);
        run_march("sa1_a127_b0", 0);
        check("sa1.fail_elem_1", fail_elem, 3'd1);
        check("sa1.fail_addr_127", fail_addr, 7'd127);

        clear_faults();
        run_march("poke200", 200);
        check("poke200.len", 128'(last_len), 128'(10 * DEPTH));

        for (int t = 0; t < 3; t++) begin
            ra = int'($urandom_range(0, DEPTH - 1));
            rb = int'($urandom_range(0, DATA_W - 1));
            rp = 1'($urandom);
            set_fault(ra, rb, rp);
            repeat (int'($urandom_range(0, 4))) tick();
            run_march($sformatf("rand%0d_a%0d_b%0d_p%0d", t, ra, rb, rp), 0);
        end

        clear_faults();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 400 && cyc < 300; i++) tick();
        check("rst.reached_300", 128'(cyc), 128'(300));
        reset = 1'b1;
        #1;
        check("rst.busy_en", {busy, W0_en, R0_en}, 3'b000);
        check("rst.all_outputs", {done, fail, fail_addr, fail_elem, W0_addr, W0_data, R0_addr},
              '0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        run_march("post_reset", 0);
        check("post_reset.len", 128'(last_len), 128'(10 * DEPTH));

        repeat (3) tick();
        check("idle_port_activity", 128'(idle_act), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
